u_scfifo_plus: RTL and testbench
================================

// Module: u_scfifo_plus
// PURPOSE
//  Single-clock FIFO model. Parametrised successor to the dual-clock FIFO model, for blocks that need no clock crossing.
//  Adds selectable show-ahead/normal read mode, programmable almost_full/almost_empty thresholds,
//  a full-range usedw that can represent LPM_NUM_WORDS, sticky overflow/underflow flags and a synchronous clear.
//  Drop-in buffer between producer/consumer stages sharing one clock.
// PARAMETERS
//  LPM_WIDTH           12                           data width, bits
//  LPM_NUM_WORDS       256                          depth, 4..131072, any value (need not be power of 2)
//  LPM_WIDTHU          $clog2(LPM_NUM_WORDS)+1      usedw width; must hold LPM_NUM_WORDS
//  LPM_SHOWAHEAD       "ON"                         "ON" = head word visible on q; "OFF" = q updates on read
//  ALMOST_FULL_VALUE   LPM_NUM_WORDS-4              almost_full = (usedw >= value)
//  ALMOST_EMPTY_VALUE  4                            almost_empty = (usedw < value)
//  OVERFLOW_CHECKING   "ON"                         "ON" enables the overflow flag
//  UNDERFLOW_CHECKING  "ON"                         "ON" enables the underflow flag
// PORTS
//  clock         in   1             single clock, rising edge
//  aclr_n        in   1             asynchronous reset, active low
//  sclr          in   1             synchronous clear, active high
//  data          in   LPM_WIDTH     write data
//  wrreq         in   1             write request
//  rdreq         in   1             read request
//  q             out  LPM_WIDTH     read data
//  empty         out  1             no words stored
//  full          out  1             usedw == LPM_NUM_WORDS
//  almost_full   out  1             usedw >= ALMOST_FULL_VALUE
//  almost_empty  out  1             usedw <  ALMOST_EMPTY_VALUE
//  usedw         out  LPM_WIDTHU    words stored, 0..LPM_NUM_WORDS
//  overflow      out  1             sticky: a write was rejected at full
//  underflow     out  1             sticky: a read was rejected at empty
// BEHAVIOUR
//  Reset: aclr_n=0 clears asynchronously. usedw=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, q=0.
//   almost_empty=1 when ALMOST_EMPTY_VALUE>0. Storage array is not reset.
//  Storage: register array with wr_ptr/rd_ptr. Pointers wrap from LPM_NUM_WORDS-1 to 0 (explicit compare; no power-of-2 mask).
//   usedw is a separate up/down counter.
//  All status outputs derive from registered usedw and reflect the state after the last edge. The status update latency after an accepted request is 1 clock.
//  Accept rules, evaluated each edge on pre-edge state:
//   wr_ok = wrreq & (~full | rdreq);
//   rd_ok = rdreq & ~empty.
//   - Simultaneous wrreq+rdreq at full: both are accepted and usedw is unchanged.
//   - Simultaneous wrreq+rdreq at empty: the write is accepted and the read is rejected. usedw becomes 1 and underflow is set.
//   - Otherwise usedw += wr_ok - rd_ok.
//  Rejected requests never move pointers or change storage, regardless of the checking parameters.
//  overflow is set at the edge where wrreq & ~wr_ok. underflow is set at the edge where rdreq & ~rd_ok.
//   Both hold until sclr or aclr_n. Each is tied 0 when its checking parameter is "OFF".
//  Show-ahead "ON": q = mem[rd_ptr] combinationally.
//   - A word written into an empty FIFO at edge N is on q and empty=0 after edge N.
//   - rd_ok at edge N advances q to the next word after edge N.
//   - q is don't-care while empty=1.
//  Show-ahead "OFF": q is a register loaded with mem[rd_ptr] at the edge where rd_ok=1, giving 1-clock read latency. q holds its value otherwise.
//  sclr: synchronous, with priority over wrreq/rdreq that cycle.
//   Pointers, usedw, overflow and underflow go to 0, and q goes to 0 in "OFF" mode. Flags return to their reset values after the edge.
//  Parameter legality (elaboration-time check):
//   - 1 <= ALMOST_FULL_VALUE <= LPM_NUM_WORDS;
//   - 0 <= ALMOST_EMPTY_VALUE <= LPM_NUM_WORDS;
//   - 2**LPM_WIDTHU > LPM_NUM_WORDS.
// TESTING
//  1 Fill: 256 writes of 1..256 with rdreq=0 -> usedw 256, full=1; almost_full rises after the 252nd write; almost_empty falls after the 4th write.
//  2 Overflow: write 0xABC at full -> overflow=1, usedw 256; draining (SHOWAHEAD ON) returns 1..256 in order, then empty=1. 0xABC never appears.
//  3 Concurrency: at full, wrreq+rdreq with data 0x777 -> usedw stays 256; 0x777 emerges last. At empty, wrreq+rdreq -> usedw 1, underflow=1.
//  4 Read mode: SHOWAHEAD OFF, write 5 then 9, pulse rdreq -> q=5 one clock after the read edge; q holds 5 until the next read returns 9.
//  5 Clear: sclr at usedw 100 with wrreq+rdreq also high -> next cycle usedw 0, empty=1, flags 0. No write is committed.
//  6 Reset: aclr_n low mid-burst, asynchronous to the clock edge -> all outputs take reset values immediately. Normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/u_scfifo_plus.sv
// Single-clock FIFO with show-ahead or registered read, programmable almost thresholds,
// full-range usedw, sticky overflow/underflow and synchronous clear.
module u_scfifo_plus #(
  parameter int    LPM_WIDTH          = 12,
  parameter int    LPM_NUM_WORDS      = 256,
  parameter int    LPM_WIDTHU         = $clog2(LPM_NUM_WORDS) + 1,
  parameter string LPM_SHOWAHEAD      = "ON",
  parameter int    ALMOST_FULL_VALUE  = LPM_NUM_WORDS - 4,
  parameter int    ALMOST_EMPTY_VALUE = 4,
  parameter string OVERFLOW_CHECKING  = "ON",
  parameter string UNDERFLOW_CHECKING = "ON"
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic [LPM_WIDTH-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [LPM_WIDTH-1:0]  q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LPM_WIDTHU-1:0] usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                    PW       = $clog2(LPM_NUM_WORDS);
  localparam logic [PW-1:0]         LAST_PTR = PW'(LPM_NUM_WORDS - 1);
  localparam logic [LPM_WIDTHU-1:0] DEPTH_U  = LPM_WIDTHU'(LPM_NUM_WORDS);
  localparam logic [LPM_WIDTHU-1:0] AF_U     = LPM_WIDTHU'(ALMOST_FULL_VALUE);
  localparam logic [LPM_WIDTHU-1:0] AE_U     = LPM_WIDTHU'(ALMOST_EMPTY_VALUE);

  if (LPM_NUM_WORDS < 4 || LPM_NUM_WORDS > 131072) begin : g_bad_depth
    $error("u_scfifo_plus: LPM_NUM_WORDS out of range 4..131072");
  end
  if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > LPM_NUM_WORDS) begin : g_bad_af
    $error("u_scfifo_plus: ALMOST_FULL_VALUE must be 1..LPM_NUM_WORDS");
  end
  if (ALMOST_EMPTY_VALUE < 0 || ALMOST_EMPTY_VALUE > LPM_NUM_WORDS) begin : g_bad_ae
    $error("u_scfifo_plus: ALMOST_EMPTY_VALUE must be 0..LPM_NUM_WORDS");
  end
  if ((64'd1 << LPM_WIDTHU) <= 64'(LPM_NUM_WORDS)) begin : g_bad_wu
    $error("u_scfifo_plus: LPM_WIDTHU too narrow to hold LPM_NUM_WORDS");
  end

  logic [LPM_WIDTH-1:0]  mem [LPM_NUM_WORDS];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LPM_WIDTHU-1:0] usedw_r;
  logic                  ovf_r;
  logic                  unf_r;
  logic                  wr_ok;
  logic                  rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Status is purely a decode of the registered count.
  assign usedw        = usedw_r;
  assign empty        = (usedw_r == '0);
  assign full         = (usedw_r == DEPTH_U);
  assign almost_full  = (usedw_r >= AF_U);
  assign almost_empty = (usedw_r < AE_U);
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

  always_comb begin
    wr_ok = wrreq & (~full | rdreq);
    rd_ok = rdreq & ~empty;
  end

  always_ff @(posedge clock) begin
    if (aclr_n && !sclr && wr_ok) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
    end else if (sclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   usedw_r <= usedw_r + 1'b1;
        2'b01:   usedw_r <= usedw_r - 1'b1;
        default: usedw_r <= usedw_r;
      endcase
    end
  end

  if (OVERFLOW_CHECKING == "ON") begin : g_ovf
    always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n)                ovf_r <= 1'b0;
      else if (sclr)              ovf_r <= 1'b0;
      else if (wrreq && !wr_ok)   ovf_r <= 1'b1;
    end
  end else begin : g_no_ovf
    assign ovf_r = 1'b0;
  end

  if (UNDERFLOW_CHECKING == "ON") begin : g_unf
    always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n)                unf_r <= 1'b0;
      else if (sclr)              unf_r <= 1'b0;
      else if (rdreq && !rd_ok)   unf_r <= 1'b1;
    end
  end else begin : g_no_unf
    assign unf_r = 1'b0;
  end

  if (LPM_SHOWAHEAD == "ON") begin : g_show_ahead
    // Gating with empty keeps q at 0 out of reset, since the array itself is never cleared.
    assign q = empty ? '0 : mem[rd_ptr];
  end else begin : g_registered
    logic [LPM_WIDTH-1:0] q_r;
    always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n)     q_r <= '0;
      else if (sclr)   q_r <= '0;
      else if (rd_ok)  q_r <= mem[rd_ptr];
    end
    assign q = q_r;
  end

endmodule

// File: tb/tb_u_scfifo_plus.sv
// Scoreboard bench for u_scfifo_plus: a 256-deep show-ahead instance and an 8-deep registered-read instance.
module tb_u_scfifo_plus;

  logic        tb_clk = 1'b0;
  logic        aclr_n;

  logic        sclr, wrreq, rdreq;
  logic [11:0] data, q;
  logic        empty, full, almost_full, almost_empty, overflow, underflow;
  logic [8:0]  usedw;

  logic        sclr_o, wrreq_o, rdreq_o;
  logic [11:0] data_o, q_o;
  logic        empty_o, full_o, almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [3:0]  usedw_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] sb[$];
  logic [11:0] sb_o[$];
  int          mcnt   = 0;
  int          mcnt_o = 0;
  logic        pend_o = 1'b0;

  always #5 tb_clk = ~tb_clk;

  u_scfifo_plus dut (
    .clock(tb_clk), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .usedw(usedw), .overflow(overflow), .underflow(underflow)
  );

  u_scfifo_plus #(.LPM_NUM_WORDS(8), .LPM_SHOWAHEAD("OFF")) dut_off (
    .clock(tb_clk), .aclr_n(aclr_n), .sclr(sclr_o), .data(data_o), .wrreq(wrreq_o), .rdreq(rdreq_o),
    .q(q_o), .empty(empty_o), .full(full_o), .almost_full(almost_full_o),
    .almost_empty(almost_empty_o), .usedw(usedw_o), .overflow(overflow_o), .underflow(underflow_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Show-ahead monitor: the word on q is consumed at the coming edge whenever a read is accepted.
  always @(negedge tb_clk) begin
    if (aclr_n && !sclr && rdreq && !empty) begin
      if (sb.size() == 0) chk("sb_underrun", 32'(q), 32'hFFFF_FFFF);
      else                chk("q_showahead", 32'(q), 32'(sb.pop_front()));
    end
  end

  // Registered-read monitor: q carries the word one cycle after the accepted read.
  always @(negedge tb_clk) begin
    if (pend_o) begin
      if (sb_o.size() == 0) chk("sb_off_underrun", 32'(q_o), 32'hFFFF_FFFF);
      else                  chk("q_registered", 32'(q_o), 32'(sb_o.pop_front()));
    end
    pend_o = aclr_n && !sclr_o && rdreq_o && !empty_o;
  end

  task automatic step(input logic wr, input logic rd, input logic [11:0] d, input logic clr = 1'b0);
    logic wok, rok;
    wrreq = wr; rdreq = rd; data = d; sclr = clr;
    if (clr) begin
      sb.delete();
      mcnt = 0;
    end else begin
      wok = wr && (mcnt < 256 || rd);
      rok = rd && (mcnt > 0);
      if (wok) sb.push_back(d);
      mcnt = mcnt + int'(wok) - int'(rok);
    end
    @(posedge tb_clk); #1;
    wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
  endtask

  task automatic step_o(input logic wr, input logic rd, input logic [11:0] d, input logic clr = 1'b0);
    logic wok, rok;
    wrreq_o = wr; rdreq_o = rd; data_o = d; sclr_o = clr;
    if (clr) begin
      sb_o.delete();
      mcnt_o = 0;
    end else begin
      wok = wr && (mcnt_o < 8 || rd);
      rok = rd && (mcnt_o > 0);
      if (wok) sb_o.push_back(d);
      mcnt_o = mcnt_o + int'(wok) - int'(rok);
    end
    @(posedge tb_clk); #1;
    wrreq_o = 1'b0; rdreq_o = 1'b0; sclr_o = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aclr_n = 1'b0;
    sclr = 0; wrreq = 0; rdreq = 0; data = '0;
    sclr_o = 0; wrreq_o = 0; rdreq_o = 0; data_o = '0;
    #12;
    chk("rst_usedw", 32'(usedw), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_q_off", 32'(q_o), 0);
    aclr_n = 1'b1;
    @(posedge tb_clk); #1;

    // Fill with 1..256.
    for (int k = 1; k <= 256; k++) begin
      step(1, 0, 12'(k));
      chk("fill_usedw", 32'(usedw), 32'(k));
      chk("fill_af", 32'(almost_full), (k >= 252) ? 1 : 0);
      chk("fill_ae", 32'(almost_empty), (k < 4) ? 1 : 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_q_head", 32'(q), 1);

    // Rejected write at full.
    step(1, 0, 12'hABC);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_usedw", 32'(usedw), 256);
    chk("ovf_unf_clear", 32'(underflow), 0);

    // Concurrent write+read at full.
    step(1, 1, 12'h777);
    chk("conc_full_usedw", 32'(usedw), 256);
    chk("conc_full_full", 32'(full), 1);

    for (int k = 0; k < 256; k++) step(0, 1, 12'h0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_usedw", 32'(usedw), 0);
    chk("drain_sb_left", 32'(sb.size()), 0);
    chk("drain_unf", 32'(underflow), 0);

    // Concurrent write+read at empty.
    step(1, 1, 12'h123);
    chk("conc_empty_usedw", 32'(usedw), 1);
    chk("conc_empty_unf", 32'(underflow), 1);
    chk("conc_empty_q", 32'(q), 32'h123);
    chk("conc_empty_empty", 32'(empty), 0);
    step(0, 1, 12'h0);
    chk("conc_empty_drained", 32'(empty), 1);

    // Synchronous clear with wr+rd also asserted.
    for (int k = 0; k < 100; k++) step(1, 0, 12'(12'h200 + k));
    chk("pre_clr_usedw", 32'(usedw), 100);
    step(1, 1, 12'h999, 1'b1);
    chk("clr_usedw", 32'(usedw), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_ae", 32'(almost_empty), 1);
    chk("clr_af", 32'(almost_full), 0);
    step(1, 0, 12'h055);
    chk("post_clr_q", 32'(q), 32'h055);
    chk("post_clr_usedw", 32'(usedw), 1);
    step(0, 1, 12'h0);

    // Registered read mode.
    step_o(1, 0, 12'd5);
    step_o(1, 0, 12'd9);
    chk("off_q_hold_rst", 32'(q_o), 0);
    chk("off_usedw", 32'(usedw_o), 2);
    step_o(0, 1, 12'h0);
    chk("off_q_first", 32'(q_o), 5);
    step_o(0, 0, 12'h0);
    step_o(0, 0, 12'h0);
    chk("off_q_hold", 32'(q_o), 5);
    step_o(0, 1, 12'h0);
    chk("off_q_second", 32'(q_o), 9);
    chk("off_empty", 32'(empty_o), 1);
    for (int k = 1; k <= 8; k++) begin
      step_o(1, 0, 12'(k));
      chk("off_fill_af", 32'(almost_full_o), (k >= 4) ? 1 : 0);
    end
    chk("off_full", 32'(full_o), 1);
    chk("off_q_during_fill", 32'(q_o), 9);
    step_o(1, 0, 12'hFFF);
    chk("off_ovf", 32'(overflow_o), 1);
    chk("off_usedw_full", 32'(usedw_o), 8);
    step_o(0, 0, 12'h0, 1'b1);
    chk("off_clr_q", 32'(q_o), 0);
    chk("off_clr_ovf", 32'(overflow_o), 0);
    chk("off_clr_usedw", 32'(usedw_o), 0);

    // Asynchronous reset in the middle of a write burst.
    for (int k = 0; k < 10; k++) step(1, 0, 12'(12'h300 + k));
    step_o(1, 0, 12'h0AA);
    wrreq = 1'b1; data = 12'hEEE;
    #3;
    aclr_n = 1'b0;
    #1;
    chk("arst_usedw", 32'(usedw), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_q", 32'(q), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_ae", 32'(almost_empty), 1);
    chk("arst_usedw_off", 32'(usedw_o), 0);
    wrreq = 1'b0;
    sb.delete();   mcnt = 0;
    sb_o.delete(); mcnt_o = 0;
    @(posedge tb_clk); #3;
    aclr_n = 1'b1;
    @(posedge tb_clk); #1;
    chk("arst_release_usedw", 32'(usedw), 0);
    step(1, 0, 12'h03C);
    chk("resume_usedw", 32'(usedw), 1);
    chk("resume_q", 32'(q), 32'h03C);
    step(0, 1, 12'h0);
    chk("resume_empty", 32'(empty), 1);
    chk("end_sb_left", 32'(sb.size()), 0);
    chk("end_sb_off_left", 32'(sb_o.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
